// File: rtl/bram_read_arbiter_if.sv
// Requester-side read channel for the shared BRAM read port.
// master = requester, slave = arbiter.
interface bram_read_arbiter_if #(
    parameter int ADDR_W = 21
);
    logic              req;
    logic [ADDR_W-1:0] addr;
    logic              ack;
    logic              rvalid;
    logic [7:0]        rdata;

    modport master (
        output req,
        output addr,
        input  ack,
        input  rvalid,
        input  rdata
    );

    modport slave (
        input  req,
        input  addr,
        output ack,
        output rvalid,
        output rdata
    );
endinterface

// File: rtl/bram_read_arbiter.sv
// Two-requester arbiter for a single pipelined BRAM read port.
// Each issued read carries a port tag through LATENCY stages so its data lands on the right port.
module bram_read_arbiter #(
    parameter int ADDR_W     = 21,
    parameter int LATENCY    = 1,
    parameter int FIXED_PRIO = 0
) (
    input  logic              clk_memory,
    input  logic              resetn,
    bram_read_arbiter_if.slave port0,
    bram_read_arbiter_if.slave port1,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_en,
    input  logic [7:0]        mem_data,
    output logic              busy
);

    logic              last_p1;
    logic              gnt0;
    logic              gnt1;
    logic [LATENCY:0]  tag_v;
    logic [LATENCY:0]  tag_p;
    logic [ADDR_W-1:0] mem_addr_q;
    logic              rvalid0_q;
    logic              rvalid1_q;
    logic [7:0]        rdata0_q;
    logic [7:0]        rdata1_q;

    // Grants are gated by resetn so nothing is acked while reset is held.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (resetn) begin
            if (port0.req && (!port1.req || (FIXED_PRIO != 0) || last_p1)) begin
                gnt0 = 1'b1;
            end else if (port1.req) begin
                gnt1 = 1'b1;
            end
        end
    end

    assign port0.ack = gnt0;
    assign port1.ack = gnt1;

    // tag_v[0] is the issue stage (mem_en); tag_v[LATENCY] lines up with mem_data.
    always_ff @(posedge clk_memory or negedge resetn) begin
        if (!resetn) begin
            last_p1    <= 1'b1;
            tag_v      <= '0;
            tag_p      <= '0;
            mem_addr_q <= '0;
            rvalid0_q  <= 1'b0;
            rvalid1_q  <= 1'b0;
            rdata0_q   <= 8'h00;
            rdata1_q   <= 8'h00;
        end else begin
            tag_v <= {tag_v[LATENCY-1:0], gnt0 | gnt1};
            tag_p <= {tag_p[LATENCY-1:0], gnt1};

            if (gnt0) begin
                mem_addr_q <= port0.addr;
                last_p1    <= 1'b0;
            end else if (gnt1) begin
                mem_addr_q <= port1.addr;
                last_p1    <= 1'b1;
            end

            rvalid0_q <= tag_v[LATENCY] & ~tag_p[LATENCY];
            rvalid1_q <= tag_v[LATENCY] &  tag_p[LATENCY];
            if (tag_v[LATENCY] && !tag_p[LATENCY]) begin
                rdata0_q <= mem_data;
            end
            if (tag_v[LATENCY] && tag_p[LATENCY]) begin
                rdata1_q <= mem_data;
            end
        end
    end

    assign mem_en       = tag_v[0];
    assign mem_addr     = mem_addr_q;
    assign busy         = |tag_v;
    assign port0.rvalid = rvalid0_q;
    assign port0.rdata  = rdata0_q;
    assign port1.rvalid = rvalid1_q;
    assign port1.rdata  = rdata1_q;

endmodule

// File: tb/tb_bram_read_arbiter.sv
// Directed bench for bram_read_arbiter: three instances cover round-robin/LATENCY=1,
// fixed priority, and LATENCY=3. Memory returns addr[7:0]^8'h5A after LATENCY cycles.
module tb_bram_read_arbiter;

    logic clk_memory = 1'b0;
    logic resetn;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk_memory = ~clk_memory;

    bram_read_arbiter_if #(.ADDR_W(21)) a0 ();
    bram_read_arbiter_if #(.ADDR_W(21)) a1 ();
    bram_read_arbiter_if #(.ADDR_W(21)) b0 ();
    bram_read_arbiter_if #(.ADDR_W(21)) b1 ();
    bram_read_arbiter_if #(.ADDR_W(21)) c0 ();
    bram_read_arbiter_if #(.ADDR_W(21)) c1 ();

    logic [20:0] a_mem_addr, b_mem_addr, c_mem_addr;
    logic        a_mem_en, b_mem_en, c_mem_en;
    logic [7:0]  a_mem_data, b_mem_data, c_mem_data;
    logic        a_busy, b_busy, c_busy;
    logic [20:0] a_q, b_q, c_q0, c_q1, c_q2;

    bram_read_arbiter #(.ADDR_W(21), .LATENCY(1), .FIXED_PRIO(0)) dut_a (
        .clk_memory(clk_memory), .resetn(resetn), .port0(a0), .port1(a1),
        .mem_addr(a_mem_addr), .mem_en(a_mem_en), .mem_data(a_mem_data), .busy(a_busy));

    bram_read_arbiter #(.ADDR_W(21), .LATENCY(1), .FIXED_PRIO(1)) dut_b (
        .clk_memory(clk_memory), .resetn(resetn), .port0(b0), .port1(b1),
        .mem_addr(b_mem_addr), .mem_en(b_mem_en), .mem_data(b_mem_data), .busy(b_busy));

    bram_read_arbiter #(.ADDR_W(21), .LATENCY(3), .FIXED_PRIO(0)) dut_c (
        .clk_memory(clk_memory), .resetn(resetn), .port0(c0), .port1(c1),
        .mem_addr(c_mem_addr), .mem_en(c_mem_en), .mem_data(c_mem_data), .busy(c_busy));

    always @(posedge clk_memory) begin
        a_q  <= a_mem_addr;
        b_q  <= b_mem_addr;
        c_q0 <= c_mem_addr;
        c_q1 <= c_q0;
        c_q2 <= c_q1;
    end

    assign a_mem_data = a_q[7:0]  ^ 8'h5A;
    assign b_mem_data = b_q[7:0]  ^ 8'h5A;
    assign c_mem_data = c_q2[7:0] ^ 8'h5A;

    task automatic chk(input string tag, input int cyc_n, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s@%0d observed %0h expected %0h", tag, cyc_n, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk_memory);
        #1;
    endtask

    initial begin
        resetn  = 1'b0;
        a0.req = 1'b1; a0.addr = '0; a1.req = 1'b1; a1.addr = '0;
        b0.req = 1'b0; b0.addr = '0; b1.req = 1'b0; b1.addr = '0;
        c0.req = 1'b0; c0.addr = '0; c1.req = 1'b0; c1.addr = '0;

        // reset state, with requests held to show acks are gated
        repeat (2) @(posedge clk_memory);
        @(negedge clk_memory);
        chk("rst_ack0",   0, 32'(a0.ack),    32'd0);
        chk("rst_ack1",   0, 32'(a1.ack),    32'd0);
        chk("rst_mem_en", 0, 32'(a_mem_en),  32'd0);
        chk("rst_maddr",  0, 32'(a_mem_addr), 32'd0);
        chk("rst_busy",   0, 32'(a_busy),    32'd0);
        chk("rst_rv0",    0, 32'(a0.rvalid), 32'd0);
        chk("rst_rd0",    0, 32'(a0.rdata),  32'd0);
        chk("rst_rd1",    0, 32'(a1.rdata),  32'd0);
        chk("rst_c_en",   0, 32'(c_mem_en),  32'd0);
        a0.req = 1'b0; a1.req = 1'b0;
        resetn = 1'b1;

        // round-robin contention: acks alternate 0,1,... and returns follow 3 cycles later
        for (int k = 0; k < 10; k++) begin
            cyc();
            a0.req  = (k < 6);
            a1.req  = (k < 6);
            a0.addr = 21'h100 + 21'((k + 1) / 2);
            a1.addr = 21'h2A0 + 21'(k / 2);
            @(negedge clk_memory);
            chk("rr_ack0",   k, 32'(a0.ack),   32'(k < 6 && k % 2 == 0));
            chk("rr_ack1",   k, 32'(a1.ack),   32'(k < 6 && k % 2 == 1));
            chk("rr_mem_en", k, 32'(a_mem_en), 32'(k >= 1 && k <= 6));
            if (k >= 3) begin
                int j;
                j = k - 3;
                chk("rr_rv0", k, 32'(a0.rvalid), 32'(j < 6 && j % 2 == 0));
                chk("rr_rv1", k, 32'(a1.rvalid), 32'(j < 6 && j % 2 == 1));
                if (j < 6 && j % 2 == 0) chk("rr_rd0", k, 32'(a0.rdata), 32'(8'(j / 2) ^ 8'h5A));
                if (j < 6 && j % 2 == 1) chk("rr_rd1", k, 32'(a1.rdata), 32'((8'hA0 + 8'(j / 2)) ^ 8'h5A));
            end
        end

        // single read from port 0
        for (int k = 0; k < 5; k++) begin
            cyc();
            a0.req  = (k == 0);
            a0.addr = 21'h012345;
            @(negedge clk_memory);
            chk("sr_rv1", k, 32'(a1.rvalid), 32'd0);
            case (k)
                0: begin
                    chk("sr_ack0",   k, 32'(a0.ack),   32'd1);
                    chk("sr_mem_en", k, 32'(a_mem_en), 32'd0);
                end
                1: begin
                    chk("sr_mem_en", k, 32'(a_mem_en),   32'd1);
                    chk("sr_maddr",  k, 32'(a_mem_addr), 32'h012345);
                    chk("sr_busy",   k, 32'(a_busy),     32'd1);
                    chk("sr_ack0",   k, 32'(a0.ack),     32'd0);
                end
                2: begin
                    chk("sr_mem_en", k, 32'(a_mem_en),  32'd0);
                    chk("sr_busy",   k, 32'(a_busy),    32'd1);
                    chk("sr_rv0",    k, 32'(a0.rvalid), 32'd0);
                end
                3: begin
                    chk("sr_rv0",  k, 32'(a0.rvalid), 32'd1);
                    chk("sr_rd0",  k, 32'(a0.rdata),  32'h1F);
                    chk("sr_busy", k, 32'(a_busy),    32'd0);
                end
                default: begin
                    chk("sr_rv0",   k, 32'(a0.rvalid),   32'd0);
                    chk("sr_rd0h",  k, 32'(a0.rdata),    32'h1F);
                    chk("sr_maddrh", k, 32'(a_mem_addr), 32'h012345);
                end
            endcase
        end

        // streaming on port 1, addresses 0..7 back to back
        for (int k = 0; k < 12; k++) begin
            cyc();
            a1.req  = (k < 8);
            a1.addr = 21'(k);
            @(negedge clk_memory);
            chk("st_ack1", k, 32'(a1.ack),    32'(k < 8));
            chk("st_busy", k, 32'(a_busy),    32'(k >= 1 && k <= 9));
            chk("st_rv1",  k, 32'(a1.rvalid), 32'(k >= 3 && k <= 10));
            chk("st_rv0",  k, 32'(a0.rvalid), 32'd0);
            if (k >= 3 && k <= 10) chk("st_rd1", k, 32'(a1.rdata), 32'(8'(k - 3) ^ 8'h5A));
        end
        chk("st_rd1h", 11, 32'(a1.rdata), 32'(8'h07 ^ 8'h5A));
        chk("st_rd0h", 11, 32'(a0.rdata), 32'h1F);

        // reset mid-flight
        for (int k = 0; k < 2; k++) begin
            cyc();
            a0.req  = 1'b1;
            a0.addr = 21'h33 + 21'(k);
            @(negedge clk_memory);
            chk("mr_ack0", k, 32'(a0.ack), 32'd1);
        end
        cyc();
        a0.req = 1'b0;
        #2;
        resetn = 1'b0;
        #1;
        chk("mr_mem_en", 2, 32'(a_mem_en),   32'd0);
        chk("mr_busy",   2, 32'(a_busy),     32'd0);
        chk("mr_maddr",  2, 32'(a_mem_addr), 32'd0);
        chk("mr_rv0",    2, 32'(a0.rvalid),  32'd0);
        a0.req = 1'b1; a1.req = 1'b1;
        #1;
        chk("mr_gate0", 2, 32'(a0.ack), 32'd0);
        chk("mr_gate1", 2, 32'(a1.ack), 32'd0);
        a0.req = 1'b0; a1.req = 1'b0;
        @(posedge clk_memory);
        @(negedge clk_memory);
        resetn = 1'b1;
        for (int k = 0; k < 5; k++) begin
            cyc();
            @(negedge clk_memory);
            chk("mr_post_rv0", k, 32'(a0.rvalid), 32'd0);
            chk("mr_post_rv1", k, 32'(a1.rvalid), 32'd0);
            chk("mr_post_en",  k, 32'(a_mem_en),  32'd0);
        end
        cyc();
        a0.req = 1'b1; a0.addr = 21'h40;
        a1.req = 1'b1; a1.addr = 21'h50;
        @(negedge clk_memory);
        chk("mr_rr_ack0", 0, 32'(a0.ack), 32'd1);
        chk("mr_rr_ack1", 0, 32'(a1.ack), 32'd0);
        cyc();
        a0.req = 1'b0;
        @(negedge clk_memory);
        chk("mr_rr_ack1", 1, 32'(a1.ack), 32'd1);
        cyc();
        a1.req = 1'b0;
        @(negedge clk_memory);
        cyc();
        @(negedge clk_memory);
        chk("mr_rv0", 3, 32'(a0.rvalid), 32'd1);
        chk("mr_rd0", 3, 32'(a0.rdata),  32'h1A);
        cyc();
        @(negedge clk_memory);
        chk("mr_rv1", 4, 32'(a1.rvalid), 32'd1);
        chk("mr_rd1", 4, 32'(a1.rdata),  32'h0A);

        // fixed priority; port 1 also moves its address while waiting
        for (int k = 0; k < 9; k++) begin
            cyc();
            b0.req  = (k < 4);
            b0.addr = 21'h10 + 21'(k);
            b1.req  = (k < 5);
            b1.addr = (k < 4) ? 21'h70 + 21'(k) : 21'h77;
            @(negedge clk_memory);
            chk("fp_ack0", k, 32'(b0.ack),    32'(k < 4));
            chk("fp_ack1", k, 32'(b1.ack),    32'(k == 4));
            chk("fp_rv0",  k, 32'(b0.rvalid), 32'(k >= 3 && k <= 6));
            chk("fp_rv1",  k, 32'(b1.rvalid), 32'(k == 7));
            if (k >= 3 && k <= 6) chk("fp_rd0", k, 32'(b0.rdata), 32'((8'h10 + 8'(k - 3)) ^ 8'h5A));
            if (k == 7) chk("fp_rd1", k, 32'(b1.rdata), 32'h2D);
        end

        // LATENCY=3 single read
        for (int k = 0; k < 7; k++) begin
            cyc();
            c0.req  = (k == 0);
            c0.addr = 21'h0ABCDE;
            @(negedge clk_memory);
            chk("l3_ack0", k, 32'(c0.ack),    32'(k == 0));
            chk("l3_rv0",  k, 32'(c0.rvalid), 32'(k == 5));
            chk("l3_busy", k, 32'(c_busy),    32'(k >= 1 && k <= 4));
            if (k == 5) chk("l3_rd0", k, 32'(c0.rdata), 32'h84);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
